freq_multiplier: RTL and testbench
==================================

Name: freq_multiplier

Overview:
- Digital frequency multiplier clocked by a fast reference clock.
- On an adjust request it measures one period of a slow asynchronous input clock f, in reference-clock cycles.
- From that count it derives a half-period divisor k and generates acc_out at approximately f × 2^n.
- Built as a controller FSM plus a datapath (synchronizer, measurement counter, k register, output divider with toggle flop).

Parameters:
- CW, 11, width of the measurement counter; saturates at 2^CW−1.
- KW, 8, width of the k register and output divider.

Ports:
- clk  input  1  reference clock; all logic is on the rising edge.
- rst  input  1  asynchronous active-high reset.
- f  input  1  slow clock to multiply; asynchronous to clk.
- adjust  input  1  level-sampled request to (re)start measurement.
- n  input  3  multiplication exponent; output frequency ≈ f·2^n. Sampled in CALC.
- valid  output  1  high while k is valid and acc_out is running.
- acc_out  output  1  multiplied clock output.
- k  output  8  current half-period divisor, in clk cycles.

Behaviour:
- Reset is asynchronous and active-high; the design uses one clock (clk).
- During reset: valid=0, acc_out=0, k=0, FSM=IDLE, all counters 0.
- f synchronizer: two-flop synchronizer to f_s, plus a delay flop f_d.
- Rising edge detection: rise = f_s & ~f_d.
- FSM states:
  - IDLE: valid=0, acc_out held at 0. If adjust=1, go to WAIT.
  - WAIT: measurement counter cleared. On rise, go to MEAS.
  - MEAS: counter increments every clk and saturates at 2^CW−1. On the next rise, go to CALC. The count C then equals the clk cycles between the two rising edges, since synchronizer latency cancels out.
  - CALC (1 cycle): k ← C >> (n+1).
    - If the result is > 255, k = 255.
    - If the result is 0, k = 1.
    - Output divider loaded with k−1; acc_out cleared to 0.
    - Go to RUN.
  - RUN: valid=1. The divider decrements each clk. When it reaches 0: toggle acc_out and reload k−1. acc_out therefore has period 2k clk cycles.
- adjust=1 in any non-IDLE state restarts the sequence:
  - go to WAIT next cycle;
  - valid drops to 0 and acc_out goes to 0 on that same edge;
  - k keeps its old value until the next CALC.
- valid timing: rises on the first clk edge after CALC. The first acc_out toggle occurs k cycles after entering RUN.
- f stuck (no second rise): remain in MEAS with the counter saturated. No timeout.
- k is registered and changes only in CALC or on reset.

Test Plan:
- Basic multiply: clk period 150 units, f period 50 clk cycles, n=2, pulse adjust.
  - Required: k=6 (50>>3), valid=1.
  - acc_out toggles every 6 clk cycles (period 12, ≈4×f).
- n=0 with the same f → k=25, acc_out period 50 cycles (equals f). n=1 → k=12.
- Clamp low: f period 50, n=7 → 50>>8=0 → k=1; acc_out toggles every clk cycle.
- Clamp high: f period 1200 clk cycles, n=0 → 600 > 255 → k=255.
- Re-adjust: while in RUN, change f to period 100 and pulse adjust.
  - valid=0 and acc_out=0 on the next edge; k stays 6 until CALC.
  - New result k=12 (n=2), then valid=1.
- Reset mid-MEAS and mid-RUN: assert rst asynchronously.
  - valid, acc_out and k go to 0 immediately, without a clk edge.
  - After release with no adjust, the block stays in IDLE.

Source files
------------

// File: rtl/freq_multiplier.sv
// Digital frequency multiplier.
// Measures one period of the slow asynchronous clock f in clk cycles, derives a
// half-period divisor k = C >> (n+1) (clamped to 1..2^KW-1) and toggles acc_out
// every k clk cycles, giving roughly f * 2^n at the output.
module freq_multiplier #(
    parameter int unsigned CW = 11,
    parameter int unsigned KW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f,
    input  logic          adjust,
    input  logic [2:0]    n,
    output logic          valid,
    output logic          acc_out,
    output logic [KW-1:0] k
);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StMeas,
        StCalc,
        StRun
    } state_e;

    localparam logic [CW-1:0] CntMax = '1;
    localparam logic [CW-1:0] KMax   = CW'((2 ** KW) - 1);

    state_e        state_q;
    logic          f_meta_q;
    logic          f_s_q;
    logic          f_d_q;
    logic          rise;
    logic [CW-1:0] cnt_q;
    logic [KW-1:0] k_q;
    logic [KW-1:0] div_q;
    logic          valid_q;
    logic          acc_q;

    logic [CW-1:0] shifted;
    logic [KW-1:0] k_calc;

    // Two-flop synchronizer for f plus a delay flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_meta_q <= 1'b0;
            f_s_q    <= 1'b0;
            f_d_q    <= 1'b0;
        end else begin
            f_meta_q <= f;
            f_s_q    <= f_meta_q;
            f_d_q    <= f_s_q;
        end
    end

    assign rise = f_s_q & ~f_d_q;

    // Divisor from the measured count, clamped so the output never stalls or overflows k
    always_comb begin
        shifted = cnt_q >> (4'(n) + 4'd1);
        k_calc  = KW'(shifted);
        if (shifted > KMax) begin
            k_calc = '1;
        end else if (shifted == '0) begin
            k_calc = KW'(1);
        end
    end

    // Controller FSM and datapath registers; adjust outside IDLE restarts the measurement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            k_q     <= '0;
            div_q   <= '0;
            valid_q <= 1'b0;
            acc_q   <= 1'b0;
        end else if (state_q != StIdle && adjust) begin
            // k deliberately keeps its old value until the next CALC
            state_q <= StWait;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            acc_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    valid_q <= 1'b0;
                    acc_q   <= 1'b0;
                    if (adjust) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    cnt_q <= '0;
                    if (rise) begin
                        state_q <= StMeas;
                    end
                end
                StMeas: begin
                    // Counting on the closing edge too makes C equal the full period
                    if (cnt_q != CntMax) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                    if (rise) begin
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    k_q     <= k_calc;
                    div_q   <= k_calc - KW'(1);
                    acc_q   <= 1'b0;
                    valid_q <= 1'b1;
                    state_q <= StRun;
                end
                StRun: begin
                    if (div_q == '0) begin
                        acc_q <= ~acc_q;
                        div_q <= k_q - KW'(1);
                    end else begin
                        div_q <= div_q - KW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign valid   = valid_q;
    assign acc_out = acc_q;
    assign k       = k_q;

endmodule

// File: tb/tb_freq_multiplier.sv
// Self-checking bench for freq_multiplier: directed and random f periods / exponents
// compared against an arithmetic model of the expected divisor and output timing.
module tb_freq_multiplier;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       f = 1'b0;
    logic       adjust = 1'b0;
    logic [2:0] n = 3'd0;
    logic       valid;
    logic       acc_out;
    logic [7:0] k;

    int checks = 0;
    int errors = 0;
    int cur_p  = 50;

    freq_multiplier #(
        .CW(11),
        .KW(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .f      (f),
        .adjust (adjust),
        .n      (n),
        .valid  (valid),
        .acc_out(acc_out),
        .k      (k)
    );

    // clk period 150; f edges offset by 37 so they never coincide with clk edges
    always #75 clk = ~clk;

    initial begin
        #37;
        forever begin
            #(cur_p * 75) f = ~f;
        end
    end

    // Expected half-period divisor for an f period of p clk cycles
    function automatic int ref_k(input int p, input int nn);
        int c;
        int q;
        c = (p > 2047) ? 2047 : p;
        q = c >> (nn + 1);
        if (q > 255) return 255;
        if (q == 0) return 1;
        return q;
    endfunction

    task automatic set_period(input int p);
        int old;
        old   = cur_p;
        cur_p = p;
        repeat (2 * old + 2 * p + 4) @(negedge clk);
    endtask

    task automatic pulse_adjust();
        @(negedge clk);
        adjust = 1'b1;
        @(negedge clk);
        adjust = 1'b0;
    endtask

    // Wait for valid, check k, then check the first three acc_out toggle intervals
    task automatic check_run(input int p, input int nn, input string tag);
        int waited;
        int exp_k;
        exp_k  = ref_k(p, nn);
        waited = 0;
        while (!valid && waited < 3 * p + 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL %s valid_timeout: got valid=%b expected 1 within %0d cycles",
                     tag, valid, 3 * p + 20);
            return;
        end
        checks++;
        if (int'(k) != exp_k) begin
            errors++;
            $display("FAIL %s k: got %0d expected %0d", tag, k, exp_k);
        end
        checks++;
        if (acc_out !== 1'b0) begin
            errors++;
            $display("FAIL %s acc_start: got %b expected 0", tag, acc_out);
        end
        for (int t = 0; t < 3; t++) begin
            int   cnt;
            logic prev;
            cnt  = 0;
            prev = acc_out;
            do begin
                @(negedge clk);
                cnt++;
            end while (acc_out === prev && cnt < 2 * exp_k + 5);
            checks++;
            if (cnt != exp_k) begin
                errors++;
                $display("FAIL %s toggle_interval%0d: got %0d cycles expected %0d",
                         tag, t, cnt, exp_k);
            end
        end
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL %s valid_hold: got %b expected 1", tag, valid);
        end
    endtask

    task automatic run_measure(input int p, input int nn, input string tag);
        if (p != cur_p) set_period(p);
        n = 3'(nn);
        pulse_adjust();
        check_run(p, nn, tag);
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (valid !== 1'b0 || acc_out !== 1'b0 || k !== 8'd0) begin
            errors++;
            $display("FAIL %s: got valid=%b acc_out=%b k=%0d expected 0/0/0",
                     tag, valid, acc_out, k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #10;
        check_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;
        repeat (120) @(negedge clk);
        check_zero("idle_no_adjust");
    endtask

    task automatic test_basic();
        run_measure(50, 2, "basic_n2");
        run_measure(50, 0, "n0");
        run_measure(50, 1, "n1");
    endtask

    task automatic test_clamp();
        run_measure(50, 7, "clamp_low");
        run_measure(1200, 0, "clamp_high");
    endtask

    task automatic test_readjust();
        run_measure(50, 2, "pre_readjust");
        set_period(100);
        pulse_adjust();
        checks++;
        if (valid !== 1'b0 || acc_out !== 1'b0) begin
            errors++;
            $display("FAIL readjust_drop: got valid=%b acc_out=%b expected 0/0", valid, acc_out);
        end
        checks++;
        if (k !== 8'd6) begin
            errors++;
            $display("FAIL readjust_k_hold: got %0d expected 6", k);
        end
        repeat (60) @(negedge clk);
        checks++;
        if (k !== 8'd6 || valid !== 1'b0) begin
            errors++;
            $display("FAIL readjust_k_hold_meas: got k=%0d valid=%b expected 6/0", k, valid);
        end
        check_run(100, 2, "readjust_new");
    endtask

    task automatic test_async_reset();
        // Reset during MEAS
        run_measure(50, 2, "pre_rst_meas");
        pulse_adjust();
        repeat (70) @(negedge clk);
        #20 rst = 1'b1;
        #1 check_zero("async_rst_meas");
        #30 rst = 1'b0;
        repeat (150) @(negedge clk);
        check_zero("idle_after_rst_meas");
        // Reset during RUN
        run_measure(50, 2, "pre_rst_run");
        repeat (5) @(negedge clk);
        #20 rst = 1'b1;
        #1 check_zero("async_rst_run");
        #30 rst = 1'b0;
        repeat (150) @(negedge clk);
        check_zero("idle_after_rst_run");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            int p;
            int nn;
            p  = int'($urandom_range(400, 8));
            nn = int'($urandom_range(7, 0));
            run_measure(p, nn, $sformatf("rand%0d_p%0d_n%0d", i, p, nn));
        end
    endtask

    task automatic test_back_to_back();
        n = 3'd2;
        pulse_adjust();
        pulse_adjust();
        check_run(cur_p, 2, "back_to_back");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_readjust();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
